msrv32_mem_arbiter: RTL and testbench



---
 rtl/msrv32_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_msrv32_mem_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/msrv32_mem_arbiter.sv
// rtl/msrv32_mem_arbiter.sv - shares one single-port memory bus between fetch and load/store
//
// Purpose: grants one requester at a time, registers the granted request onto
// the bus, returns a one-cycle ack with read data, and aborts hung bus cycles.
//
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, sync active-high reset
//   i_req_in, i_addr_in -> i_data_out, i_ack_out : instruction fetch port
//   d_req_in, d_wr_in, d_addr_in, d_wdata_in, d_mask_in
//                       -> d_rdata_out, d_ack_out : load/store port
//   mem_req_out, mem_wr_out, mem_addr_out, mem_wdata_out, mem_mask_out,
//   mem_rdata_in, mem_ack_in                      : external memory bus
//   stall_out   : pipeline stall while any request is outstanding
//   bus_err_out : one-cycle pulse when a bus transaction is aborted
module msrv32_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    ms_riscv32_mp_clk_in,
  input  logic                    ms_riscv32_mp_rst_in,
  input  logic                    i_req_in,
  input  logic [ADDR_WIDTH-1:0]   i_addr_in,
  output logic [DATA_WIDTH-1:0]   i_data_out,
  output logic                    i_ack_out,
  input  logic                    d_req_in,
  input  logic                    d_wr_in,
  input  logic [ADDR_WIDTH-1:0]   d_addr_in,
  input  logic [DATA_WIDTH-1:0]   d_wdata_in,
  input  logic [DATA_WIDTH/8-1:0] d_mask_in,
  output logic [DATA_WIDTH-1:0]   d_rdata_out,
  output logic                    d_ack_out,
  output logic                    mem_req_out,
  output logic                    mem_wr_out,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_wdata_out,
  output logic [DATA_WIDTH/8-1:0] mem_mask_out,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_in,
  input  logic                    mem_ack_in,
  output logic                    stall_out,
  output logic                    bus_err_out
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t        state;
  logic          last_grant_d;  // 1 = most recent grant went to the data port
  logic [CW-1:0] count;

  logic elig_i, elig_d, grant_i, grant_d;

  assign stall_out = (i_req_in & ~i_ack_out) | (d_req_in & ~d_ack_out);

  // A port whose ack is on the wire this cycle still shows its old req;
  // masking it prevents a second grant for an already served request.
  always_comb begin
    elig_i  = i_req_in & ~i_ack_out;
    elig_d  = d_req_in & ~d_ack_out;
    grant_d = elig_d & (~elig_i | ~last_grant_d);
    grant_i = elig_i & ~grant_d;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state         <= IDLE;
      last_grant_d  <= 1'b0;
      count         <= '0;
      mem_req_out   <= 1'b0;
      mem_wr_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_mask_out  <= '0;
      i_data_out    <= '0;
      d_rdata_out   <= '0;
      i_ack_out     <= 1'b0;
      d_ack_out     <= 1'b0;
      bus_err_out   <= 1'b0;
    end else begin
      i_ack_out   <= 1'b0;
      d_ack_out   <= 1'b0;
      bus_err_out <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_req_out   <= 1'b1;
            mem_wr_out    <= d_wr_in;
            mem_addr_out  <= d_addr_in;
            mem_wdata_out <= d_wdata_in;
            mem_mask_out  <= d_wr_in ? d_mask_in : '0;
            last_grant_d  <= 1'b1;
            count         <= '0;
            state         <= D_BUSY;
          end else if (grant_i) begin
            mem_req_out   <= 1'b1;
            mem_wr_out    <= 1'b0;
            mem_addr_out  <= i_addr_in;
            mem_wdata_out <= '0;
            mem_mask_out  <= '0;
            last_grant_d  <= 1'b0;
            count         <= '0;
            state         <= I_BUSY;
          end
        end
        I_BUSY, D_BUSY: begin
          // An ack in the final counted cycle takes priority over the abort.
          if (mem_ack_in) begin
            mem_req_out <= 1'b0;
            if (state == I_BUSY) begin
              i_ack_out  <= 1'b1;
              i_data_out <= mem_rdata_in;
            end else begin
              d_ack_out <= 1'b1;
              if (!mem_wr_out) d_rdata_out <= mem_rdata_in;
            end
            state <= IDLE;
          end else if (count == LAST_COUNT) begin
            mem_req_out <= 1'b0;
            bus_err_out <= 1'b1;
            if (state == I_BUSY) begin
              i_ack_out  <= 1'b1;
              i_data_out <= '0;
            end else begin
              d_ack_out   <= 1'b1;
              d_rdata_out <= '0;
            end
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_mem_arbiter.sv
// tb/tb_msrv32_mem_arbiter.sv - randomized bench for msrv32_mem_arbiter against a transaction model
module tb_msrv32_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 4;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_ack;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data;
  logic          d_req, d_wr, d_ack;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [MW-1:0] d_mask;
  logic          mem_req, mem_wr, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_mask;
  logic          stall, bus_err;

  always #5 clk = ~clk;

  msrv32_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .i_req_in(i_req),
    .i_addr_in(i_addr),
    .i_data_out(i_data),
    .i_ack_out(i_ack),
    .d_req_in(d_req),
    .d_wr_in(d_wr),
    .d_addr_in(d_addr),
    .d_wdata_in(d_wdata),
    .d_mask_in(d_mask),
    .d_rdata_out(d_rdata),
    .d_ack_out(d_ack),
    .mem_req_out(mem_req),
    .mem_wr_out(mem_wr),
    .mem_addr_out(mem_addr),
    .mem_wdata_out(mem_wdata),
    .mem_mask_out(mem_mask),
    .mem_rdata_in(mem_rdata),
    .mem_ack_in(mem_ack),
    .stall_out(stall),
    .bus_err_out(bus_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: who owns the bus, how long it has been outstanding,
  // and the values every output should show in the current cycle.
  int            owner;        // 0 none, 1 fetch, 2 data
  int            age;          // bus cycles already spent without an ack
  bit            last_was_d;
  logic          e_req, e_wr, e_i_ack, e_d_ack, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_idata, e_drdata;
  logic [MW-1:0] e_mask;

  task automatic model_reset();
    owner = 0; age = 0; last_was_d = 0;
    e_req = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_mask = '0;
    e_idata = '0; e_drdata = '0; e_i_ack = 0; e_d_ack = 0; e_err = 0;
  endtask

  task automatic model_step();
    bit want_i, want_d, pick_d;
    logic [DW-1:0] result;
    bit done, aborted;
    want_i = i_req && !e_i_ack;
    want_d = d_req && !e_d_ack;
    e_i_ack = 0; e_d_ack = 0; e_err = 0;
    if (owner == 0) begin
      if (want_i || want_d) begin
        pick_d = want_d && !(want_i && last_was_d);
        last_was_d = pick_d;
        owner = pick_d ? 2 : 1;
        age = 0;
        e_req   = 1;
        e_wr    = pick_d ? d_wr : 1'b0;
        e_addr  = pick_d ? d_addr : i_addr;
        e_wdata = pick_d ? d_wdata : '0;
        e_mask  = (pick_d && d_wr) ? d_mask : '0;
      end
    end else begin
      done    = mem_ack;
      aborted = !mem_ack && (age + 1 >= TO);
      if (done || aborted) begin
        result = aborted ? '0 : mem_rdata;
        e_req = 0;
        e_err = aborted;
        if (owner == 1) begin
          e_i_ack = 1;
          e_idata = result;
        end else begin
          e_d_ack = 1;
          if (aborted || !e_wr) e_drdata = result;
        end
        owner = 0;
      end else begin
        age++;
      end
    end
  endtask

  bit i_acked_prev, d_acked_prev;

  initial begin
    rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_wr = 0; d_addr = '0;
    d_wdata = '0; d_mask = '0; mem_ack = 0; mem_rdata = '0;
    i_acked_prev = 0; d_acked_prev = 0;
    model_reset();
    @(posedge clk); #1;
    for (int c = 0; c < NCYC; c++) begin
      check_eq("mem_req",   {63'd0, mem_req}, {63'd0, e_req});
      check_eq("mem_wr",    {63'd0, mem_wr},  {63'd0, e_wr});
      check_eq("mem_addr",  {32'd0, mem_addr},  {32'd0, e_addr});
      check_eq("mem_wdata", {32'd0, mem_wdata}, {32'd0, e_wdata});
      check_eq("mem_mask",  {60'd0, mem_mask},  {60'd0, e_mask});
      check_eq("i_ack",     {63'd0, i_ack},   {63'd0, e_i_ack});
      check_eq("d_ack",     {63'd0, d_ack},   {63'd0, e_d_ack});
      check_eq("bus_err",   {63'd0, bus_err}, {63'd0, e_err});
      check_eq("i_data",    {32'd0, i_data},  {32'd0, e_idata});
      check_eq("d_rdata",   {32'd0, d_rdata}, {32'd0, e_drdata});

      rst = (c < 2) || ($urandom_range(0, 79) == 0);

      // Requesters hold req through the ack cycle, then drop or re-request.
      if (!e_i_ack && !(i_req && !i_acked_prev)) begin
        i_req  = $urandom_range(0, 1) == 1;
        i_addr = $urandom;
      end
      i_acked_prev = e_i_ack;
      if (!e_d_ack && !(d_req && !d_acked_prev)) begin
        d_req   = $urandom_range(0, 1) == 1;
        d_wr    = $urandom_range(0, 1) == 1;
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_mask  = MW'($urandom_range(0, 15));
      end
      d_acked_prev = e_d_ack;

      mem_ack   = $urandom_range(0, 9) < 3;
      mem_rdata = $urandom;

      #1;
      check_eq("stall", {63'd0, stall},
               {63'd0, (i_req && !e_i_ack) || (d_req && !e_d_ack)});

      if (rst) model_reset();
      else model_step();
      @(posedge clk); #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
